// File: rtl/led_anim_sequencer.sv
// Frame sequencer: steps the 8-entry pattern table and holds each frame on led for div_l cycles.
// Latency: start accepted at edge N -> LOAD after N, new led + frame_strobe after N+1.
// No backpressure: start/stop are one-cycle requests, stop wins over start in the same cycle.
module led_anim_sequencer #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] frame_div,
  output logic [2:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic [7:0]       led,
  output logic             busy,
  output logic             frame_strobe,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [7:0]       led_q, led_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             dir_down_q, dir_down_d;
  logic [1:0]       mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;

  // State and output registers; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 3'd0;
      led_q      <= 8'h00;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      mode_q     <= 2'd0;
      div_q      <= DIV_W'(2);
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
    end
  end

  // Next-state logic: stop, then start, then the playback FSM proper.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    led_d      = led_q;
    busy_d     = busy_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    mode_d     = mode_q;
    div_d      = div_q;

    if (stop) begin
      state_d    = S_IDLE;
      addr_d     = 3'd0;
      led_d      = 8'h00;
      busy_d     = 1'b0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else if (start) begin
      // Periods below 2 cannot fit one LOAD plus at least one WAIT cycle.
      mode_d     = mode;
      div_d      = (frame_div < DIV_W'(2)) ? DIV_W'(2) : frame_div;
      addr_d     = 3'd0;
      dir_down_d = 1'b0;
      busy_d     = 1'b1;
      cnt_d      = '0;
      state_d    = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD: begin
          led_d    = rom_data;
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          cnt_d = cnt_q + DIV_W'(1);
          if (cnt_q == div_q - DIV_W'(2)) begin
            state_d = S_LOAD;
            case (mode_q)
              MODE_ONESHOT: begin
                if (addr_q == 3'd7) state_d = S_FINISH;
                else                addr_d  = addr_q + 3'd1;
              end
              MODE_PINGPONG: begin
                // Flip at the endpoint itself so 0 and 7 are shown once per pass.
                if (dir_down_q) begin
                  addr_d = addr_q - 3'd1;
                  if (addr_q == 3'd1) dir_down_d = 1'b0;
                end else begin
                  addr_d = addr_q + 3'd1;
                  if (addr_q == 3'd6) dir_down_d = 1'b1;
                end
              end
              default: addr_d = addr_q + 3'd1;
            endcase
          end
        end
        S_FINISH: begin
          // led keeps frame 7 on purpose; only busy and the address are cleared.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          addr_d  = 3'd0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rom_addr     = addr_q;
  assign led          = led_q;
  assign busy         = busy_q;
  assign frame_strobe = strobe_q;
  assign done         = done_q;

endmodule
